// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the two-master data-memory arbiter.
package cpu_bus_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_e;

  // Master indices, also the encoding of the owner output.
  localparam logic MST_CPU    = 1'b0;
  localparam logic MST_LOADER = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin tie-break: a lone requester wins outright, on a tie
// the master that did not win last time is chosen.
module rr_arb2
  import cpu_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner
);

  // Pure combinational pick; with no request the last owner is held.
  always_comb begin
    winner = last_owner;
    if (req0 && !req1) begin
      winner = MST_CPU;
    end else if (req1 && !req0) begin
      winner = MST_LOADER;
    end else if (req0 && req1) begin
      winner = ~last_owner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port word memory.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for a request; arbitrate and latch the winner's fields
//   ST_ACCESS | drive memory from latched fields; capture read data at exit
//   ST_ACK    | one-cycle ack/err/rdata pulse to the owner only
module mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  owner
);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  range_q, range_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  grant;
  logic                  sel_we;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic                  unused_addr_lsbs;

  rr_arb2 u_rr_arb2 (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (owner_q),
    .winner     (grant)
  );

  assign sel_we    = grant ? m1_we    : m0_we;
  assign sel_addr  = grant ? m1_addr  : m0_addr;
  assign sel_wdata = grant ? m1_wdata : m0_wdata;

  // Byte lanes are not used: every access is a full word.
  assign unused_addr_lsbs = ^sel_addr[1:0];

  // Next-state logic: arbitrate and latch in IDLE, capture read data in ACCESS.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    range_d = range_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ST_ACCESS;
          owner_d = grant;
          we_d    = sel_we;
          addr_d  = sel_addr[ADDR_WIDTH+1:2];
          wdata_d = sel_wdata;
          range_d = (sel_addr[31:ADDR_WIDTH+2] == '0);
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        rdata_d = (range_q && !we_q) ? mem_rdata : 32'd0;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; mem_we is gated by rst so an aborted write never lands.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    m0_rdata  = 32'd0;
    m1_rdata  = 32'd0;
    if (state_q == ST_ACCESS) begin
      mem_we    = we_q && range_q && !rst;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    if (state_q == ST_ACK) begin
      if (owner_q == MST_LOADER) begin
        m1_ack   = 1'b1;
        m1_err   = !range_q;
        m1_rdata = rdata_q;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = !range_q;
        m0_rdata = rdata_q;
      end
    end
  end

  assign owner = owner_q;

  // State and datapath registers; owner resets to the loader so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= MST_LOADER;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      range_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      range_q <= range_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-address width of the shared data memory (depth 2**ADDR_WIDTH words).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 m0_req  input  1  CPU-side master request; held high with stable fields until m0_ack.
REQ-005 m0_we  input  1  master 0 write enable (1 = write, 0 = read).
REQ-006 m0_addr  input  32  master 0 byte address.
REQ-007 m0_wdata  input  32  master 0 write data.
REQ-008 m0_rdata  output  32  master 0 read data; valid only in the m0_ack cycle.
REQ-009 m0_ack  output  1  one-cycle completion pulse to master 0.
REQ-010 m0_err  output  1  out-of-range flag; valid only in the m0_ack cycle.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same directions, widths and meanings for master 1 (loader/debug port).
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 mem_addr  output  ADDR_WIDTH  memory word address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_rdata  input  32  memory read data, combinational from mem_addr.
REQ-016 owner  output  1  index of the master most recently granted.

Function
REQ-017 FSM states: IDLE, ACCESS, ACK. Transitions: IDLE->ACCESS when any req is high; ACCESS->ACK always; ACK->IDLE always.
REQ-018 Arbitration in IDLE only: one requester wins outright; if both request, the master that is not owner wins (round-robin); the grant is latched into owner on entry to ACCESS.
REQ-019 On entry to ACCESS, the granted master's we, addr and wdata are registered; memory sees only registered values.
REQ-020 In ACCESS: mem_addr = latched addr[ADDR_WIDTH+1:2]; mem_wdata = latched wdata; mem_we = latched we AND in-range.
REQ-021 In-range means latched addr[31:ADDR_WIDTH+2] == 0; addr[1:0] is ignored (word access only).
REQ-022 At the end of ACCESS, mem_rdata is registered into the read-data register; for an out-of-range access or a write, 0 is registered instead.
REQ-023 In ACK: only the owner's ack is high, for exactly one cycle; its rdata is the registered data and its err is 1 if out of range; the other master's ack, err and rdata are 0.
REQ-024 Outside ACCESS, mem_we = 0 and mem_addr and mem_wdata are 0; outside ACK, all ack, err and rdata outputs are 0.
REQ-025 Latency: req sampled high in IDLE at cycle N gives ack at cycle N+2; peak throughput is one access per 3 cycles.
REQ-026 A req dropped during ACCESS or ACK does not abort the access: the write still completes and ack still pulses.
REQ-027 A req held high through ACK is treated as a new request in the following IDLE.
REQ-028 An out-of-range write never asserts mem_we.

Reset
REQ-029 rst is sampled synchronously; while it is high the FSM is forced to IDLE, owner = 1 (so master 0 wins the first tie), and the latched fields and read-data register are cleared to 0.
REQ-030 Reset during ACCESS drops mem_we in the same cycle that reset is sampled; no ack is produced for the aborted access.

Structure
REQ-031 The FSM state encoding and the master-index constants live in a shared package (cpu_bus_pkg).
REQ-032 The round-robin tie-break is a sub-module rr_arb2 (inputs: two req lines and last-owner; output: winner index).
REQ-033 Total flop count is at most 110: FSM, owner, we, addr, wdata, range flag and read data.

Verification
REQ-034 Single read: memory word 5 = 0xDEADBEEF; m0 reads 0x14 -> m0_ack at N+2 with m0_rdata = 0xDEADBEEF, m0_err = 0.
REQ-035 Write then read: m1 writes 0x12345678 to 0x40, then m1 reads 0x40 -> mem_we high for exactly one cycle with mem_addr = 16; the read returns 0x12345678.
REQ-036 Tie after reset: m0 and m1 both request continuously -> grants alternate m0, m1, m0, m1, with acks every 3 cycles.
REQ-037 Out of range: m0 writes 0x00001000 with ADDR_WIDTH = 10 -> mem_we stays 0; m0_ack with m0_err = 1 and m0_rdata = 0.
REQ-038 Reset mid-access: rst asserted during the ACCESS cycle of an m1 write -> no ack; memory unchanged; the next simultaneous request is granted to m0.
REQ-039 Dropped request: m0_req deasserted in the ACCESS cycle of a write -> the write still lands and m0_ack still pulses once.
